rd_data_checker: RTL and testbench

//  Read-side consumer of cmp_pkt_t: pairs Avalon-MM readdata beats with queued compare packets.

---
 rtl/rd_data_checker_pkg.sv | 76 +++++++
 rtl/rd_data_checker_cmp_pkt_fifo.sv | 49 ++++
 rtl/rd_data_checker.sv | 244 ++++++++++++++++++++++++
 tb/tb_rd_data_checker.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rd_data_checker_pkg.sv
// Shared types and pattern helpers for the read-side data checker.
// The write-side pattern generator uses the same functions.
package rd_data_checker_pkg;

  localparam int AMM_DATA_W  = 32;
  localparam int DATA_B_W    = AMM_DATA_W / 8;
  localparam int AMM_BURST_W = 8;
  localparam int ADDR_W      = 16;

  localparam logic [7:0] LFSR_POLY = 8'hB8;

  typedef enum logic {
    PKT_NOCMP = 1'b0,
    PKT_CMP   = 1'b1
  } pkt_type_e;

  typedef enum logic {
    FIX_DATA = 1'b0,
    RND_DATA = 1'b1
  } ptrn_mode_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } chk_state_e;

  typedef struct packed {
    pkt_type_e              pkt_type;
    ptrn_mode_e             mode;
    logic [7:0]             data_ptrn;
    logic [ADDR_W-1:0]      word_addr;
    logic [AMM_BURST_W-1:0] word_count;
    logic [DATA_B_W-1:0]    start_mask;
    logic [DATA_B_W-1:0]    end_mask;
    logic [DATA_B_W-1:0]    middle_mask;
  } cmp_pkt_t;

  function automatic logic [7:0] lfsr8_next(
    input logic [7:0] s
  );
    if (s[0]) return (s >> 1) ^ LFSR_POLY;
    return s >> 1;
  endfunction

  function automatic logic [7:0] lfsr8_seed(
    input logic [7:0] p
  );
    return (p == 8'h00) ? 8'hFF : p;
  endfunction

  function automatic logic [AMM_DATA_W-1:0] exp_word(
    input logic [7:0] ptrn,
    input ptrn_mode_e mode
  );
    logic [7:0]            s;
    logic [AMM_DATA_W-1:0] w;
    s = ptrn;
    w = '0;
    for (int b = 0; b < DATA_B_W; b++) begin
      s = lfsr8_next(s);
      w[b*8 +: 8] = (mode == RND_DATA) ? s : ptrn;
    end
    return w;
  endfunction

  function automatic logic [AMM_DATA_W-1:0] byte_to_bit(
    input logic [DATA_B_W-1:0] m
  );
    logic [AMM_DATA_W-1:0] r;
    r = '0;
    for (int b = 0; b < DATA_B_W; b++)
      r[b*8 +: 8] = {8{m[b]}};
    return r;
  endfunction

endpackage

// File: rtl/rd_data_checker_cmp_pkt_fifo.sv
// Show-ahead synchronous FIFO of compare packets.
// Head is valid whenever empty is low.
module cmp_pkt_fifo
  import rd_data_checker_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  cmp_pkt_t               wr_pkt,
  output cmp_pkt_t               head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] usedw
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  cmp_pkt_t       mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;

  // Packet storage, no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_pkt;
  end

  // Pointers and fill level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      usedw  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      usedw <= usedw + (AW+1)'(1);
      else if (pop && !push) usedw <= usedw - (AW+1)'(1);
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (usedw == FULL_CNT);
  assign empty = (usedw == '0);

endmodule

// File: rtl/rd_data_checker.sv
// Pairs readdata beats with queued compare packets, regenerates the
// expected pattern, compares under byte masks and keeps error stats.
module rd_data_checker
  import rd_data_checker_pkg::*;
#(
  parameter int CMP_FIFO_DEPTH = 8,
  parameter int ERR_CNT_W      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  clear_i,
  input  cmp_pkt_t              cmp_pkt_i,
  input  logic                  cmp_pkt_valid_i,
  output logic                  cmp_pkt_ready_o,
  input  logic [AMM_DATA_W-1:0] rd_data_i,
  input  logic                  rd_data_valid_i,
  output logic                  busy_o,
  output logic                  err_o,
  output logic [ERR_CNT_W-1:0]  err_cnt_o,
  output logic                  first_err_vld_o,
  output logic [ADDR_W-1:0]     first_err_addr_o,
  output logic [AMM_DATA_W-1:0] first_err_data_o,
  output logic [AMM_DATA_W-1:0] first_err_exp_o,
  output logic                  orphan_err_o
);

  localparam int UW = $clog2(CMP_FIFO_DEPTH) + 1;
  localparam logic [AMM_BURST_W-1:0] ONE = AMM_BURST_W'(1);

  cmp_pkt_t               head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic [UW-1:0]          fifo_usedw;

  chk_state_e             state_q, state_d;
  cmp_pkt_t               pkt_q, pkt_d;
  logic [AMM_BURST_W-1:0] idx_q, idx_d;
  logic [7:0]             lfsr_q, lfsr_d;

  cmp_pkt_t               cur_pkt;
  logic [AMM_BURST_W-1:0] cur_idx;
  logic [7:0]             cur_lfsr;
  logic                   have_pkt;
  logic                   beat;
  logic                   last;
  logic                   first;
  logic                   orphan;
  logic [DATA_B_W-1:0]    cur_mask;
  logic [AMM_DATA_W-1:0]  cur_bits;
  logic [AMM_DATA_W-1:0]  rnd_word;
  logic [AMM_DATA_W-1:0]  cur_exp;
  logic [7:0]             rnd_next;
  logic [ADDR_W-1:0]      cur_addr;

  logic                   s1_vld, s1_cmp;
  logic [AMM_DATA_W-1:0]  s1_data, s1_exp, s1_bits;
  logic [ADDR_W-1:0]      s1_addr;
  logic                   s2_vld;
  logic [AMM_DATA_W-1:0]  s2_data, s2_exp;
  logic [ADDR_W-1:0]      s2_addr;

  assign fifo_push       = cmp_pkt_valid_i & cmp_pkt_ready_o;
  assign cmp_pkt_ready_o = ~fifo_full;

  cmp_pkt_fifo #(
    .DEPTH (CMP_FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk_i),
    .rst_n  (rst_n_i),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .wr_pkt (cmp_pkt_i),
    .head   (head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .usedw  (fifo_usedw)
  );

  // A beat in IDLE belongs to the head packet popped that same cycle.
  always_comb begin
    have_pkt = 1'b0;
    cur_pkt  = head;
    cur_idx  = '0;
    cur_lfsr = lfsr8_seed(head.data_ptrn);
    if (state_q == ST_ACTIVE) begin
      have_pkt = 1'b1;
      cur_pkt  = pkt_q;
      cur_idx  = idx_q;
      cur_lfsr = lfsr_q;
    end else if (!fifo_empty && head.word_count != '0) begin
      have_pkt = 1'b1;
    end
  end

  assign beat   = rd_data_valid_i & have_pkt;
  assign orphan = rd_data_valid_i & ~have_pkt;
  assign first  = (cur_idx == '0);
  assign last   = (cur_idx == cur_pkt.word_count - ONE);

  // Byte-enable selection for the current beat position.
  always_comb begin
    cur_mask = cur_pkt.middle_mask;
    unique case (1'b1)
      first && last:  cur_mask = cur_pkt.start_mask & cur_pkt.end_mask;
      first && !last: cur_mask = cur_pkt.start_mask;
      !first && last: cur_mask = cur_pkt.end_mask;
      default:        cur_mask = cur_pkt.middle_mask;
    endcase
  end

  assign cur_bits = byte_to_bit(cur_mask);
  assign rnd_word = exp_word(cur_lfsr, RND_DATA);
  assign rnd_next = rnd_word[AMM_DATA_W-1 -: 8];
  assign cur_exp  = (cur_pkt.mode == RND_DATA) ? rnd_word :
                    exp_word(cur_pkt.data_ptrn, FIX_DATA);
  assign cur_addr = cur_pkt.word_addr + ADDR_W'(cur_idx);

  // Packet sequencing: pop, beat counting and LFSR stepping.
  always_comb begin
    state_d  = state_q;
    pkt_d    = pkt_q;
    idx_d    = idx_q;
    lfsr_d   = lfsr_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (head.word_count != '0) begin
            pkt_d   = head;
            state_d = (beat && last) ? ST_IDLE : ST_ACTIVE;
            idx_d   = beat ? ONE : '0;
            lfsr_d  = beat ? rnd_next : cur_lfsr;
          end
        end
      end
      ST_ACTIVE: begin
        if (beat) begin
          if (!last) begin
            idx_d  = idx_q + ONE;
            lfsr_d = rnd_next;
          end else if (!fifo_empty) begin
            fifo_pop = 1'b1;
            pkt_d    = head;
            idx_d    = '0;
            lfsr_d   = lfsr8_seed(head.data_ptrn);
            if (head.word_count == '0) state_d = ST_IDLE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      pkt_q   <= '0;
      idx_q   <= '0;
      lfsr_q  <= '0;
    end else begin
      state_q <= state_d;
      pkt_q   <= pkt_d;
      idx_q   <= idx_d;
      lfsr_q  <= lfsr_d;
    end
  end

  // S1: capture beat data with its expected word, mask and address.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_vld  <= 1'b0;
      s1_cmp  <= 1'b0;
      s1_data <= '0;
      s1_exp  <= '0;
      s1_bits <= '0;
      s1_addr <= '0;
    end else begin
      s1_vld  <= beat;
      s1_cmp  <= beat && (cur_pkt.pkt_type == PKT_CMP);
      s1_data <= rd_data_i;
      s1_exp  <= cur_exp & cur_bits;
      s1_bits <= cur_bits;
      s1_addr <= cur_addr;
    end
  end

  // S2: registered compare result.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s2_vld  <= 1'b0;
      err_o   <= 1'b0;
      s2_data <= '0;
      s2_exp  <= '0;
      s2_addr <= '0;
    end else begin
      s2_vld  <= s1_vld;
      err_o   <= s1_cmp && (((s1_data ^ s1_exp) & s1_bits) != '0);
      s2_data <= s1_data;
      s2_exp  <= s1_exp;
      s2_addr <= s1_addr;
    end
  end

  // Error statistics; clear drops any coincident error.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_cnt_o        <= '0;
      first_err_vld_o  <= 1'b0;
      first_err_addr_o <= '0;
      first_err_data_o <= '0;
      first_err_exp_o  <= '0;
      orphan_err_o     <= 1'b0;
    end else if (clear_i) begin
      err_cnt_o        <= '0;
      first_err_vld_o  <= 1'b0;
      first_err_addr_o <= '0;
      first_err_data_o <= '0;
      first_err_exp_o  <= '0;
      orphan_err_o     <= 1'b0;
    end else begin
      if (err_o && err_cnt_o != '1)
        err_cnt_o <= err_cnt_o + ERR_CNT_W'(1);
      if (err_o && !first_err_vld_o) begin
        first_err_vld_o  <= 1'b1;
        first_err_addr_o <= s2_addr;
        first_err_data_o <= s2_data;
        first_err_exp_o  <= s2_exp;
      end
      if (orphan) orphan_err_o <= 1'b1;
    end
  end

  assign busy_o = (state_q == ST_ACTIVE) | ~fifo_empty | s1_vld | s2_vld;

  a_fifo_level: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    fifo_full == (fifo_usedw == UW'(CMP_FIFO_DEPTH)));

endmodule

// File: tb/tb_rd_data_checker.sv
// Directed bench for rd_data_checker with a packet-level reference model
// compared against the DUT every cycle.
module tb_rd_data_checker;
  import rd_data_checker_pkg::*;

  logic                  clk;
  logic                  rst_n;
  logic                  clear;
  cmp_pkt_t              pkt;
  logic                  pkt_valid;
  logic                  pkt_ready;
  logic [AMM_DATA_W-1:0] rd_data;
  logic                  rd_valid;
  logic                  busy;
  logic                  err;
  logic [31:0]           err_cnt;
  logic                  f_vld;
  logic [ADDR_W-1:0]     f_addr;
  logic [AMM_DATA_W-1:0] f_data;
  logic [AMM_DATA_W-1:0] f_exp;
  logic                  orphan;

  int n_chk  = 0;
  int n_pass = 0;
  bit run_chk = 0;

  rd_data_checker #(
    .CMP_FIFO_DEPTH (8),
    .ERR_CNT_W      (32)
  ) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .clear_i          (clear),
    .cmp_pkt_i        (pkt),
    .cmp_pkt_valid_i  (pkt_valid),
    .cmp_pkt_ready_o  (pkt_ready),
    .rd_data_i        (rd_data),
    .rd_data_valid_i  (rd_valid),
    .busy_o           (busy),
    .err_o            (err),
    .err_cnt_o        (err_cnt),
    .first_err_vld_o  (f_vld),
    .first_err_addr_o (f_addr),
    .first_err_data_o (f_data),
    .first_err_exp_o  (f_exp),
    .orphan_err_o     (orphan)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [ADDR_W-1:0]     addr;
    logic [AMM_DATA_W-1:0] exp;
    logic [AMM_DATA_W-1:0] bits;
    bit                    cmp;
  } beat_t;

  beat_t mq[$];

  logic                  m_err, p_err;
  logic [31:0]           m_cnt;
  logic                  m_fvld, m_orph;
  logic [ADDR_W-1:0]     m_faddr, m_eaddr, p_addr;
  logic [AMM_DATA_W-1:0] m_fdata, m_edata, p_data;
  logic [AMM_DATA_W-1:0] m_fexp, m_eexp, p_exp;

  function automatic logic [7:0] step(input logic [7:0] s);
    logic [7:0] r;
    r = {1'b0, s[7:1]};
    if (s[0]) r = r ^ 8'hB8;
    return r;
  endfunction

  // Expand a packet into its list of expected beats.
  task automatic add_pkt(input cmp_pkt_t p);
    logic [7:0]          s;
    logic [DATA_B_W-1:0] m;
    beat_t               b;
    int                  wc;
    s  = (p.data_ptrn == 8'h00) ? 8'hFF : p.data_ptrn;
    wc = int'(p.word_count);
    for (int i = 0; i < wc; i++) begin
      if (wc == 1)           m = p.start_mask & p.end_mask;
      else if (i == 0)       m = p.start_mask;
      else if (i == wc - 1)  m = p.end_mask;
      else                   m = p.middle_mask;
      b.addr = p.word_addr + ADDR_W'(i);
      b.bits = '0;
      b.exp  = '0;
      for (int k = 0; k < DATA_B_W; k++) begin
        s = step(s);
        b.bits[k*8 +: 8] = {8{m[k]}};
        b.exp[k*8 +: 8]  = (p.mode == RND_DATA) ? s : p.data_ptrn;
      end
      b.exp = b.exp & b.bits;
      b.cmp = (p.pkt_type == PKT_CMP);
      mq.push_back(b);
    end
  endtask

  always @(posedge clk) begin
    beat_t b;
    if (!rst_n) begin
      mq.delete();
      m_err = 0; p_err = 0; m_cnt = 0; m_fvld = 0; m_orph = 0;
      m_faddr = 0; m_fdata = 0; m_fexp = 0;
      m_eaddr = 0; m_edata = 0; m_eexp = 0;
      p_addr = 0; p_data = 0; p_exp = 0;
    end else begin
      if (clear) begin
        m_cnt = 0; m_fvld = 0; m_orph = 0;
        m_faddr = 0; m_fdata = 0; m_fexp = 0;
      end else if (m_err) begin
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        if (!m_fvld) begin
          m_fvld = 1; m_faddr = m_eaddr; m_fdata = m_edata; m_fexp = m_eexp;
        end
      end
      m_err = p_err; m_eaddr = p_addr; m_edata = p_data; m_eexp = p_exp;
      p_err = 0;
      if (rd_valid) begin
        if (mq.size() == 0) begin
          if (!clear) m_orph = 1;
        end else begin
          b = mq.pop_front();
          p_err  = b.cmp && (((rd_data ^ b.exp) & b.bits) != '0);
          p_addr = b.addr;
          p_data = rd_data;
          p_exp  = b.exp;
        end
      end
      if (pkt_valid) add_pkt(pkt);
    end
  end

  // Every-cycle comparison of DUT against the model.
  initial forever begin
    @(posedge clk);
    #1;
    if (rst_n && run_chk) begin
      check("err_o", 64'(err), 64'(m_err));
      check("err_cnt", 64'(err_cnt), 64'(m_cnt));
      check("orphan", 64'(orphan), 64'(m_orph));
      check("first_vld", 64'(f_vld), 64'(m_fvld));
      check("first_addr", 64'(f_addr), 64'(m_faddr));
      check("first_data", 64'(f_data), 64'(m_fdata));
      check("first_exp", 64'(f_exp), 64'(m_fexp));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic cmp_pkt_t mk(
    input pkt_type_e t, input ptrn_mode_e md, input logic [7:0] pt,
    input logic [ADDR_W-1:0] a, input logic [AMM_BURST_W-1:0] wc,
    input logic [DATA_B_W-1:0] sm, input logic [DATA_B_W-1:0] em,
    input logic [DATA_B_W-1:0] mm);
    cmp_pkt_t p;
    p.pkt_type = t; p.mode = md; p.data_ptrn = pt; p.word_addr = a;
    p.word_count = wc; p.start_mask = sm; p.end_mask = em;
    p.middle_mask = mm;
    return p;
  endfunction

  task automatic push_pkt(input cmp_pkt_t p);
    pkt = p;
    pkt_valid = 1'b1;
    tick();
    pkt_valid = 1'b0;
  endtask

  task automatic send(input logic [AMM_DATA_W-1:0] d);
    rd_data  = d;
    rd_valid = 1'b1;
    tick();
    rd_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 0; clear = 0; pkt = '0; pkt_valid = 0; rd_data = '0; rd_valid = 0;
    repeat (3) tick();
    rst_n = 1;
    tick();
    run_chk = 1;
    check("rst_ready", 64'(pkt_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_cnt", 64'(err_cnt), 64'd0);
    check("rst_fvld", 64'(f_vld), 64'd0);
    check("rst_orphan", 64'(orphan), 64'd0);

    // 1: fixed pattern, clean beat
    push_pkt(mk(PKT_CMP, FIX_DATA, 8'hA5, 16'h0100, 8'd1, 4'hF, 4'hF, 4'hF));
    send(32'hA5A5A5A5);
    tick();
    check("t1_busy_hold", 64'(busy), 64'd1);
    tick();
    check("t1_busy_drop", 64'(busy), 64'd0);
    check("t1_cnt", 64'(err_cnt), 64'd0);

    // 2a: bad byte 3 masked off
    push_pkt(mk(PKT_CMP, FIX_DATA, 8'hA5, 16'h0100, 8'd1, 4'h7, 4'hF, 4'hF));
    send(32'h00A5A5A5);
    tick(); tick();
    check("t2a_cnt", 64'(err_cnt), 64'd0);

    // 2b: bad byte 3 enabled
    push_pkt(mk(PKT_CMP, FIX_DATA, 8'hA5, 16'h0100, 8'd1, 4'hF, 4'hF, 4'hF));
    send(32'h00A5A5A5);
    tick();
    check("t2b_err", 64'(err), 64'd1);
    tick();
    check("t2b_cnt", 64'(err_cnt), 64'd1);
    check("t2b_addr", 64'(f_addr), 64'h100);
    check("t2b_data", 64'(f_data), 64'h00A5A5A5);
    check("t2b_exp", 64'(f_exp), 64'hA5A5A5A5);

    do_clear();
    check("clr_cnt", 64'(err_cnt), 64'd0);
    check("clr_fvld", 64'(f_vld), 64'd0);

    // 3: LFSR pattern, beat 1 corrupted
    push_pkt(mk(PKT_CMP, RND_DATA, 8'h01, 16'h0200, 8'd3, 4'hF, 4'hF, 4'hF));
    send(32'h172E5CB8);
    send(32'h64C9E1B3);
    send(32'h5AB41932);
    repeat (3) tick();
    check("t3_cnt", 64'(err_cnt), 64'd1);
    check("t3_addr", 64'(f_addr), 64'h201);
    check("t3_exp", 64'(f_exp), 64'h64C8E1B3);
    check("t3_data", 64'(f_data), 64'h64C9E1B3);

    do_clear();

    // 4: two packets, back-to-back beats, address wrap
    push_pkt(mk(PKT_CMP, FIX_DATA, 8'h3C, 16'hFFFF, 8'd2, 4'hF, 4'hF, 4'h0));
    push_pkt(mk(PKT_CMP, FIX_DATA, 8'hC3, 16'h0300, 8'd1, 4'hF, 4'hF, 4'hF));
    send(32'h3C3C3C3C);
    send(32'h3C3C3C3D);
    send(32'hC3C3C2C3);
    tick();
    check("t4_busy_hold", 64'(busy), 64'd1);
    tick();
    check("t4_busy_drop", 64'(busy), 64'd0);
    check("t4_cnt", 64'(err_cnt), 64'd2);
    check("t4_addr", 64'(f_addr), 64'h0000);
    check("t4_exp", 64'(f_exp), 64'h3C3C3C3C);

    // 4b: uncompared packet and middle/end masks
    push_pkt(mk(PKT_NOCMP, FIX_DATA, 8'h11, 16'h0010, 8'd2, 4'hF, 4'hF, 4'hF));
    send(32'hDEADBEEF);
    send(32'hCAFEF00D);
    push_pkt(mk(PKT_CMP, FIX_DATA, 8'h77, 16'h0020, 8'd3, 4'hF, 4'h1, 4'h0));
    send(32'h77777777);
    send(32'hDEADBEEF);
    send(32'h12345677);
    repeat (3) tick();
    check("t4b_cnt", 64'(err_cnt), 64'd2);

    // 5: orphan beat
    send(32'h12345678);
    check("t5_orphan", 64'(orphan), 64'd1);
    tick(); tick();
    check("t5_cnt", 64'(err_cnt), 64'd2);
    do_clear();
    check("t5_orphan_clr", 64'(orphan), 64'd0);

    // 7: zero-length packet is discarded ahead of a real one
    push_pkt(mk(PKT_CMP, FIX_DATA, 8'h55, 16'h0030, 8'd0, 4'hF, 4'hF, 4'hF));
    push_pkt(mk(PKT_CMP, FIX_DATA, 8'h66, 16'h0040, 8'd1, 4'hF, 4'hF, 4'hF));
    tick();
    send(32'h99666666);
    repeat (3) tick();
    check("t7_cnt", 64'(err_cnt), 64'd1);
    check("t7_addr", 64'(f_addr), 64'h40);
    check("t7_orphan", 64'(orphan), 64'd0);

    // 6: fill the queue, then reset mid-packet
    pkt = mk(PKT_CMP, FIX_DATA, 8'h99, 16'h0500, 8'd4, 4'hF, 4'hF, 4'hF);
    pkt_valid = 1'b1;
    n = 0;
    for (int i = 0; i < 20 && pkt_ready; i++) begin
      tick();
      n++;
    end
    pkt_valid = 1'b0;
    check("t6_ready_full", 64'(pkt_ready), 64'd0);
    check("t6_push_cnt", 64'(n), 64'd9);
    send(32'h99999999);
    send(32'h99999998);
    rst_n = 0;
    #1;
    check("t6_rst_ready", 64'(pkt_ready), 64'd1);
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_cnt", 64'(err_cnt), 64'd0);
    check("t6_rst_fvld", 64'(f_vld), 64'd0);
    check("t6_rst_err", 64'(err), 64'd0);
    tick(); tick();
    rst_n = 1;
    tick();

    // post-reset sanity packet
    push_pkt(mk(PKT_CMP, FIX_DATA, 8'h5A, 16'h0600, 8'd1, 4'hF, 4'hF, 4'hF));
    send(32'h5A5A5A5A);
    repeat (3) tick();
    check("post_cnt", 64'(err_cnt), 64'd0);
    check("post_busy", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
